// File: rtl/led_frame_sequencer.sv
// Frame-level sequencer for an RGB LED string: walks pixels 0..NUM_LEDS-1 with a
// ship/done handshake, times the latch period, and optionally repeats frames.
module led_frame_sequencer #(
  parameter int NUM_LEDS     = 8,
  parameter int LATCH_CYCLES = 2500,
  parameter int GAP_CYCLES   = 0,
  parameter int FRAME_W      = 16,
  parameter int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               clr,
  input  logic               continuous,
  input  logic               stop,
  input  logic               lost,
  input  logic               done,
  output logic               ship,
  output logic               ship_clr,
  output logic [IDX_W-1:0]   led_idx,
  output logic               ready,
  output logic               latching,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               stop_pending
);

  localparam int CNT_MAX = (LATCH_CYCLES > GAP_CYCLES) ? LATCH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, SHIP, NEXT, LATCH, GAP} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               clr_mode, clr_mode_next;
  logic               pend_next;
  logic               abort, abort_next;
  logic [FRAME_W-1:0] fcnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      led_idx      <= '0;
      cnt          <= '0;
      clr_mode     <= 1'b0;
      stop_pending <= 1'b0;
      abort        <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_next;
      led_idx      <= idx_next;
      cnt          <= cnt_next;
      clr_mode     <= clr_mode_next;
      stop_pending <= pend_next;
      abort        <= abort_next;
      frame_cnt    <= fcnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    idx_next      = led_idx;
    cnt_next      = cnt;
    clr_mode_next = clr_mode;
    pend_next     = stop_pending;
    abort_next    = abort;
    fcnt_next     = frame_cnt;
    frame_done    = 1'b0;

    if (state != IDLE && (stop || lost)) pend_next = 1'b1;

    case (state)
      IDLE: begin
        if (go) begin
          state_next    = SHIP;
          clr_mode_next = 1'b0;
        end else if (clr) begin
          state_next    = SHIP;
          clr_mode_next = 1'b1;
        end
      end
      SHIP: begin
        // lost outranks a coincident done: the partial frame is closed by a full latch
        if (lost) begin
          abort_next = 1'b1;
          state_next = LATCH;
          cnt_next   = LATCH_LOAD;
        end else if (done) begin
          if (led_idx == LAST_IDX) begin
            state_next = LATCH;
            cnt_next   = LATCH_LOAD;
          end else begin
            state_next = NEXT;
          end
        end
      end
      NEXT: begin
        if (lost) begin
          abort_next = 1'b1;
          state_next = LATCH;
          cnt_next   = LATCH_LOAD;
        end else begin
          idx_next   = led_idx + 1'b1;
          state_next = SHIP;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          frame_done = 1'b1;
          fcnt_next  = frame_cnt + 1'b1;
          idx_next   = '0;
          if (clr_mode || !continuous || stop_pending || abort) begin
            state_next = IDLE;
          end else if (GAP_CYCLES == 0) begin
            state_next = SHIP;
          end else begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      GAP: begin
        if (stop || stop_pending) state_next = IDLE;
        else if (cnt == '0)       state_next = SHIP;
        else                      cnt_next   = cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // run-scoped flags are cleared on the way into IDLE so IDLE never shows them
    if (state_next == IDLE) begin
      idx_next   = '0;
      pend_next  = 1'b0;
      abort_next = 1'b0;
    end
  end

  assign ready    = (state == IDLE);
  assign ship     = (state == SHIP);
  assign latching = (state == LATCH);
  assign ship_clr = clr_mode && (state != IDLE);

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: expected pixel/frame events are queued
// as stimulus is issued and matched when ship rises or frame_done pulses.
module tb_led_frame_sequencer;

  localparam int NUM_LEDS = 3;
  localparam int LATCH_CYCLES = 4;
  localparam int GAP_CYCLES = 2;
  localparam int FRAME_W = 2;
  localparam int IDX_W = 2;

  logic clk = 1'b0;
  logic reset, go, clr, continuous, stop, lost, done;
  logic ship, ship_clr, ready, latching, frame_done, stop_pending;
  logic [IDX_W-1:0] led_idx;
  logic [FRAME_W-1:0] frame_cnt;

  led_frame_sequencer #(
    .NUM_LEDS(NUM_LEDS), .LATCH_CYCLES(LATCH_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .FRAME_W(FRAME_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .continuous(continuous),
    .stop(stop), .lost(lost), .done(done), .ship(ship), .ship_clr(ship_clr),
    .led_idx(led_idx), .ready(ready), .latching(latching), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .stop_pending(stop_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_frame;
    int idx;
    bit clr;
    int fcnt;
  } ev_t;

  ev_t sb[$];
  int checks = 0;
  int failures = 0;
  int exp_fcnt = 0;
  int lat_run = 0;
  bit ship_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pixels(input int n, input bit c);
    for (int i = 0; i < n; i++) sb.push_back('{1'b0, i, c, 0});
  endtask

  task automatic push_frame(input bit c);
    sb.push_back('{1'b1, 0, c, exp_fcnt});
    exp_fcnt = (exp_fcnt + 1) % (1 << FRAME_W);
  endtask

  // Monitor: pops the scoreboard on each ship rise and each frame_done pulse
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      lat_run = 0;
      ship_q  = 1'b0;
    end else begin
      if (latching) lat_run++;
      else lat_run = 0;
      if (ship && !ship_q) begin
        if (sb.size() == 0) chk("sb_underflow_pixel", 0, 1);
        else begin
          e = sb.pop_front();
          chk("pixel_kind", 32'(e.is_frame), 0);
          chk("pixel_idx", 32'(led_idx), 32'(e.idx));
          chk("pixel_clr", 32'(ship_clr), 32'(e.clr));
        end
      end
      if (frame_done) begin
        if (sb.size() == 0) chk("sb_underflow_frame", 0, 1);
        else begin
          e = sb.pop_front();
          chk("frame_kind", 32'(e.is_frame), 1);
          chk("frame_cnt_pre", 32'(frame_cnt), 32'(e.fcnt));
          chk("frame_clr", 32'(ship_clr), 32'(e.clr));
          chk("latch_len", 32'(lat_run), LATCH_CYCLES);
        end
      end
      ship_q = ship;
    end
  end

  task automatic wait_ship();
    int n = 0;
    while (!ship && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ship) chk("ship_timeout", 0, 1);
  endtask

  // Answers the current pixel dly cycles after ship is seen; optionally raises lost with done
  task automatic serve_pixel(input int dly, input bit with_lost);
    wait_ship();
    repeat (dly) @(negedge clk);
    done = 1'b1;
    lost = with_lost;
    @(negedge clk);
    done = 1'b0;
    lost = 1'b0;
  endtask

  task automatic wait_frame_done();
    int n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic pulse_start(input bit g, input bit c);
    go = g;
    clr = c;
    @(negedge clk);
    go = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    int gap;
    reset = 1'b1; go = 0; clr = 0; continuous = 0; stop = 0; lost = 0; done = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_ship", ship, 0);
    chk("rst_latching", latching, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_led_idx", led_idx, 0);
    chk("rst_stop_pending", stop_pending, 0);
    chk("rst_ship_clr", ship_clr, 0);
    reset = 1'b0;
    @(negedge clk);

    // spurious done in IDLE
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("idle_done_ready", ready, 1);
    chk("idle_done_ship", ship, 0);

    // single data frame
    push_pixels(NUM_LEDS, 1'b0);
    push_frame(1'b0);
    pulse_start(1'b1, 1'b0);
    chk("go_ship_latency", ship, 1);
    for (int i = 0; i < NUM_LEDS; i++) serve_pixel(5, 1'b0);
    chk("latch_after_last", latching, 1);
    wait_frame_done();
    @(negedge clk);
    chk("single_ready", ready, 1);
    chk("single_fcnt", frame_cnt, 32'(exp_fcnt));

    // clear run, continuous set but still returns to IDLE
    continuous = 1'b1;
    push_pixels(NUM_LEDS, 1'b1);
    push_frame(1'b1);
    pulse_start(1'b0, 1'b1);
    for (int i = 0; i < NUM_LEDS; i++) serve_pixel(2, 1'b0);
    chk("clr_latch_ship_clr", ship_clr, 1);
    wait_frame_done();
    @(negedge clk);
    chk("clr_ready", ready, 1);
    chk("clr_fcnt", frame_cnt, 32'(exp_fcnt));

    // continuous with stop during pixel 1 of frame 2; frame_cnt also wraps 3->0
    push_pixels(NUM_LEDS, 1'b0);
    push_frame(1'b0);
    push_pixels(NUM_LEDS, 1'b0);
    push_frame(1'b0);
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < NUM_LEDS; i++) serve_pixel(3, 1'b0);
    wait_frame_done();
    gap = 0;
    while (!ship && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("cont_gap", 32'(gap), GAP_CYCLES + 1);
    chk("cont_fcnt_mid", frame_cnt, 3);
    serve_pixel(3, 1'b0);
    wait_ship();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_pending_set", stop_pending, 1);
    serve_pixel(3, 1'b0);
    serve_pixel(3, 1'b0);
    chk("stop_frame_completes", latching, 1);
    wait_frame_done();
    @(negedge clk);
    chk("stop_ready", ready, 1);
    chk("wrap_fcnt", frame_cnt, 0);
    continuous = 1'b0;

    // abort: lost together with done on pixel 1
    sb.push_back('{1'b0, 0, 1'b0, 0});
    sb.push_back('{1'b0, 1, 1'b0, 0});
    push_frame(1'b0);
    pulse_start(1'b1, 1'b0);
    serve_pixel(2, 1'b0);
    serve_pixel(2, 1'b1);
    chk("abort_latching", latching, 1);
    chk("abort_pending", stop_pending, 1);
    wait_frame_done();
    @(negedge clk);
    chk("abort_ready", ready, 1);
    chk("abort_pending_clr", stop_pending, 0);
    chk("abort_fcnt", frame_cnt, 32'(exp_fcnt));

    // reset in latch cycle 2
    push_pixels(NUM_LEDS, 1'b0);
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < NUM_LEDS; i++) serve_pixel(1, 1'b0);
    @(negedge clk);
    chk("pre_reset_latching", latching, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_fcnt = 0;
    chk("midrst_ready", ready, 1);
    chk("midrst_latching", latching, 0);
    chk("midrst_fcnt", frame_cnt, 0);
    chk("midrst_frame_done", frame_done, 0);

    // go and clr together, with a spurious done held into NEXT
    push_pixels(NUM_LEDS, 1'b0);
    push_frame(1'b0);
    pulse_start(1'b1, 1'b1);
    chk("goclr_ship_clr", ship_clr, 0);
    wait_ship();
    done = 1'b1;
    @(negedge clk);
    chk("next_state_ship", ship, 0);
    @(negedge clk);
    done = 1'b0;
    chk("next_done_ignored_ship", ship, 1);
    chk("next_done_ignored_idx", led_idx, 1);
    serve_pixel(1, 1'b0);
    serve_pixel(1, 1'b0);
    wait_frame_done();
    @(negedge clk);
    chk("goclr_ready", ready, 1);
    chk("goclr_fcnt", frame_cnt, 32'(exp_fcnt));

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
